// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
//
// Game-flow sequencer for the maze game. Walks the player through the title
// screen, play, level/world advance banners, life-loss banner and the
// terminal WIN / LOSE screens. The current world, level and life count feed
// the Obstacles/Scrolls/Screens generators; game_status feeds the screen
// logic.
//
// Optional feature (compile-time macro GAME_BONUS_LIFE_EN):
//   defined   - every entry to WORLD_INC awards one life, saturating at
//               MAX_LIVES.
//   undefined - lives change only on reset, game-start reload or death.
//
// Ports:
//   clk            in   1        system clock
//   rst            in   1        synchronous active-high reset
//   start_btn      in   1        start button (level), edge-detected inside
//   player_status  in   2        0=playing 1=level pass 2=died 3=ignored
//   game_status    out  3        current state code (see table below)
//   world          out  WORLD_W  current world index
//   level          out  LEVEL_W  current level index within the world
//   lives          out  LIVES_W  remaining lives
//   level_start    out  1        one-cycle pulse on every entry to PLAYING
//
// All outputs are registered: a decision taken on inputs sampled at edge N
// is visible right after edge N.
// ---------------------------------------------------------------------------
//
// state       | code | meaning
// ------------+------+----------------------------------------------------
// sStart      |  0   | title screen, waiting for a start press
// sPlaying    |  1   | level in progress, watching player_status
// sLevelInc   |  2   | "next level" banner, held HOLD_CYCLES cycles
// sWorldInc   |  3   | "next world" banner, held HOLD_CYCLES cycles
// sLifeLost   |  4   | "life lost" banner, held HOLD_CYCLES cycles
// sLose       |  5   | out of lives; a press returns to the title
// sWin        |  6   | last level of last world cleared; press to title
// (7)         |  -   | unused; recovers to sStart on the next edge
// ---------------------------------------------------------------------------

module game_flow_ctrl #(
    parameter int NUM_WORLDS       = 4,
    parameter int LEVELS_PER_WORLD = 6,
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 9,
    parameter int HOLD_CYCLES      = 50000000,
    parameter int WORLD_W          = 3,
    parameter int LEVEL_W          = 3,
    parameter int LIVES_W          = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic [1:0]         player_status,
    output logic [2:0]         game_status,
    output logic [WORLD_W-1:0] world,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic               level_start
);

    // -----------------------------------------------------------------------
    // Parameter sanity checks (elaboration time)
    // -----------------------------------------------------------------------
    if (NUM_WORLDS < 1 || NUM_WORLDS > (2 ** WORLD_W)) begin : gBadWorlds
        $error("game_flow_ctrl: NUM_WORLDS must be 1..2**WORLD_W");
    end
    if (LEVELS_PER_WORLD < 1 || LEVELS_PER_WORLD > (2 ** LEVEL_W)) begin : gBadLevels
        $error("game_flow_ctrl: LEVELS_PER_WORLD must be 1..2**LEVEL_W");
    end
    if (MAX_LIVES >= (2 ** LIVES_W)) begin : gBadMaxLives
        $error("game_flow_ctrl: MAX_LIVES must be < 2**LIVES_W");
    end
    if (START_LIVES < 1 || START_LIVES > MAX_LIVES) begin : gBadStartLives
        $error("game_flow_ctrl: START_LIVES must be 1..MAX_LIVES");
    end
    if (HOLD_CYCLES < 1) begin : gBadHold
        $error("game_flow_ctrl: HOLD_CYCLES must be >= 1");
    end

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    // The hold counter only ever reaches HOLD_CYCLES-1, so $clog2 of the
    // cycle count is enough bits (with a floor of one bit).
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST  = LEVEL_W'(LEVELS_PER_WORLD - 1);
    localparam logic [WORLD_W-1:0] WORLD_LAST  = WORLD_W'(NUM_WORLDS - 1);
    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_MAX   = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);

    // -----------------------------------------------------------------------
    // State encoding matches the game_status code seen by the screen logic
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        sStart    = 3'd0,
        sPlaying  = 3'd1,
        sLevelInc = 3'd2,
        sWorldInc = 3'd3,
        sLifeLost = 3'd4,
        sLose     = 3'd5,
        sWin      = 3'd6
    } stateT;

    stateT             state;
    logic [HOLD_W-1:0] holdCnt;
    logic              startPrev;
    logic              startPress;
    logic              holdDone;
    logic              lastLevel;
    logic              lastWorld;
    logic              lastLife;
    logic [LIVES_W-1:0] livesOnWorldInc;

    // A press is a rising edge of the button; holding it yields one press.
    assign startPress = start_btn & ~startPrev;
    assign holdDone   = (holdCnt == HOLD_LAST);
    assign lastLevel  = (level >= LEVEL_LAST);
    assign lastWorld  = (world >= WORLD_LAST);
    // Treat 0 as "last" as well so a death can never underflow the count.
    assign lastLife   = (lives <= LIVES_ONE);

`ifdef GAME_BONUS_LIFE_EN
    assign livesOnWorldInc = (lives < LIVES_MAX) ? lives + LIVES_ONE : LIVES_MAX;
`else
    assign livesOnWorldInc = lives;
`endif

    // -----------------------------------------------------------------------
    // Flow FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= sStart;
            world       <= '0;
            level       <= '0;
            lives       <= LIVES_START;
            level_start <= 1'b0;
            holdCnt     <= '0;
            startPrev   <= 1'b0;
        end else begin
            startPrev   <= start_btn;
            level_start <= 1'b0;

            case (state)
                sStart: begin
                    if (startPress) begin
                        state       <= sPlaying;
                        world       <= '0;
                        level       <= '0;
                        lives       <= LIVES_START;
                        level_start <= 1'b1;
                    end
                end

                sPlaying: begin
                    // Keeping the counter clear here means every banner
                    // entered from PLAYING starts counting from zero.
                    holdCnt <= '0;
                    case (player_status)
                        2'd1: begin
                            if (!lastLevel) begin
                                state <= sLevelInc;
                                level <= level + 1'b1;
                            end else if (!lastWorld) begin
                                state <= sWorldInc;
                                world <= world + 1'b1;
                                level <= '0;
                                lives <= livesOnWorldInc;
                            end else begin
                                state <= sWin;
                            end
                        end
                        2'd2: begin
                            if (!lastLife) begin
                                state <= sLifeLost;
                                lives <= lives - LIVES_ONE;
                            end else begin
                                state <= sLose;
                                lives <= '0;
                            end
                        end
                        default: begin
                            state <= sPlaying;
                        end
                    endcase
                end

                sLevelInc, sWorldInc, sLifeLost: begin
                    // Counter updates were applied on entry; the banner only
                    // has to sit out exactly HOLD_CYCLES cycles.
                    if (holdDone) begin
                        state       <= sPlaying;
                        holdCnt     <= '0;
                        level_start <= 1'b1;
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end

                sWin, sLose: begin
                    // Counters stay on screen until the next game start.
                    if (startPress) begin
                        state <= sStart;
                    end
                end

                default: begin
                    state   <= sStart;
                    holdCnt <= '0;
                end
            endcase
        end
    end

    assign game_status = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

    localparam int HOLD = 4;
    localparam int NW   = 2;
    localparam int LPW  = 2;
    localparam int SL   = 2;
`ifdef GAME_BONUS_LIFE_EN
    localparam int BONUS = 1;
`else
    localparam int BONUS = 0;
`endif

    logic       clk;
    logic       rst;
    logic       start_btn;
    logic [1:0] player_status;
    logic [2:0] game_status;
    logic [2:0] world;
    logic [2:0] level;
    logic [3:0] lives;
    logic       level_start;

    int tests;
    int fails;

    game_flow_ctrl #(
        .NUM_WORLDS      (NW),
        .LEVELS_PER_WORLD(LPW),
        .START_LIVES     (SL),
        .MAX_LIVES       (9),
        .HOLD_CYCLES     (HOLD),
        .WORLD_W         (3),
        .LEVEL_W         (3),
        .LIVES_W         (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .player_status(player_status),
        .game_status  (game_status),
        .world        (world),
        .level        (level),
        .lives        (lives),
        .level_start  (level_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until PLAYING (bounded); returns number of non-PLAYING samples
    // seen, or -1 if the bound expired.
    task automatic wait_playing(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (game_status == 3'd1) return;
            n++;
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_btn = 1'b0; player_status = 2'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        tests++;
        if (game_status !== 3'd0) begin fails++; $display("FAIL reset_status got %0d want 0", game_status); end
        tests++;
        if (world !== 3'd0 || level !== 3'd0) begin fails++; $display("FAIL reset_wl got %0d/%0d want 0/0", world, level); end
        tests++;
        if (lives !== 4'd2) begin fails++; $display("FAIL reset_lives got %0d want 2", lives); end
        tests++;
        if (level_start !== 1'b0) begin fails++; $display("FAIL reset_ls got %0d want 0", level_start); end
    endtask

    task automatic test_start_hold();
        int pulses;
        pulses = 0;
        start_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (level_start === 1'b1) pulses++;
        end
        start_btn = 1'b0;
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL hold_pulses got %0d want 1", pulses); end
        tests++;
        if (game_status !== 3'd1) begin fails++; $display("FAIL hold_status got %0d want 1", game_status); end
        player_status = 2'd3;
        tick(); tick(); tick();
        player_status = 2'd0;
        tests++;
        if (game_status !== 3'd1 || level_start !== 1'b0) begin
            fails++; $display("FAIL status3_ignored got st=%0d ls=%0d want 1/0", game_status, level_start);
        end
    endtask

    task automatic test_level_inc();
        int held;
        player_status = 2'd1;
        tick();
        player_status = 2'd0;
        tests++;
        if (game_status !== 3'd2 || level !== 3'd1) begin
            fails++; $display("FAIL lvl_entry got st=%0d lvl=%0d want 2/1", game_status, level);
        end
        held = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (game_status == 3'd2) held++;
            else break;
        end
        tests++;
        if (held != HOLD) begin fails++; $display("FAIL lvl_hold got %0d want %0d", held, HOLD); end
        tests++;
        if (game_status !== 3'd1 || level_start !== 1'b1) begin
            fails++; $display("FAIL lvl_exit got st=%0d ls=%0d want 1/1", game_status, level_start);
        end
        tick();
        tests++;
        if (level_start !== 1'b0) begin fails++; $display("FAIL lvl_ls_one got %0d want 0", level_start); end
    endtask

    task automatic test_world_inc_and_win();
        int n;
        player_status = 2'd1;
        tick();
        player_status = 2'd0;
        tests++;
        if (game_status !== 3'd3 || world !== 3'd1 || level !== 3'd0) begin
            fails++; $display("FAIL world_entry got st=%0d w=%0d l=%0d want 3/1/0", game_status, world, level);
        end
        tests++;
        if (lives !== 4'(SL + BONUS)) begin
            fails++; $display("FAIL world_lives got %0d want %0d", lives, SL + BONUS);
        end
        wait_playing(n);
        tests++;
        if (n != HOLD - 1) begin fails++; $display("FAIL world_hold got %0d want %0d", n, HOLD - 1); end
        player_status = 2'd1;
        tick();
        player_status = 2'd0;
        wait_playing(n);
        tests++;
        if (level !== 3'd1 || world !== 3'd1 || n != HOLD - 1) begin
            fails++; $display("FAIL w1_lvl got w=%0d l=%0d n=%0d want 1/1/%0d", world, level, n, HOLD - 1);
        end
        player_status = 2'd1;
        tick();
        tests++;
        if (game_status !== 3'd6 || world !== 3'd1 || level !== 3'd1 || lives !== 4'(SL + BONUS)) begin
            fails++; $display("FAIL win got st=%0d w=%0d l=%0d lv=%0d want 6/1/1/%0d",
                              game_status, world, level, lives, SL + BONUS);
        end
        player_status = 2'd2;
        tick(); tick();
        player_status = 2'd0;
        tests++;
        if (game_status !== 3'd6) begin fails++; $display("FAIL win_terminal got %0d want 6", game_status); end
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tests++;
        if (game_status !== 3'd0 || world !== 3'd1 || level !== 3'd1) begin
            fails++; $display("FAIL win_to_start got st=%0d w=%0d l=%0d want 0/1/1", game_status, world, level);
        end
        tick();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tests++;
        if (game_status !== 3'd1 || world !== 3'd0 || level !== 3'd0 || lives !== 4'd2 || level_start !== 1'b1) begin
            fails++; $display("FAIL reload got st=%0d w=%0d l=%0d lv=%0d ls=%0d want 1/0/0/2/1",
                              game_status, world, level, lives, level_start);
        end
        tick();
    endtask

    task automatic test_life_lost();
        int n;
        player_status = 2'd2;
        tick();
        player_status = 2'd0;
        tests++;
        if (game_status !== 3'd4 || lives !== 4'd1 || world !== 3'd0 || level !== 3'd0) begin
            fails++; $display("FAIL life_lost got st=%0d lv=%0d w=%0d l=%0d want 4/1/0/0",
                              game_status, lives, world, level);
        end
        wait_playing(n);
        tests++;
        if (n != HOLD - 1 || level_start !== 1'b1) begin
            fails++; $display("FAIL life_hold got n=%0d ls=%0d want %0d/1", n, level_start, HOLD - 1);
        end
        player_status = 2'd2;
        tick();
        player_status = 2'd0;
        tests++;
        if (game_status !== 3'd5 || lives !== 4'd0) begin
            fails++; $display("FAIL lose got st=%0d lv=%0d want 5/0", game_status, lives);
        end
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tests++;
        if (game_status !== 3'd0 || lives !== 4'd0) begin
            fails++; $display("FAIL lose_to_start got st=%0d lv=%0d want 0/0", game_status, lives);
        end
        tick();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tests++;
        if (game_status !== 3'd1 || lives !== 4'd2) begin
            fails++; $display("FAIL replay got st=%0d lv=%0d want 1/2", game_status, lives);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        int n;
        player_status = 2'd1;
        tick();
        player_status = 2'd0;
        wait_playing(n);
        player_status = 2'd1;
        tick();
        player_status = 2'd0;
        wait_playing(n);
        tests++;
        if (world !== 3'd1 || lives !== 4'(SL + BONUS) || n != HOLD - 1) begin
            fails++; $display("FAIL mid_setup got w=%0d lv=%0d n=%0d want 1/%0d/%0d", world, lives, n, SL + BONUS, HOLD - 1);
        end
        player_status = 2'd2;
        tick();
        player_status = 2'd0;
        tick();
        tests++;
        if (game_status !== 3'd4 || lives !== 4'(SL + BONUS - 1)) begin
            fails++; $display("FAIL mid_lifelost got st=%0d lv=%0d want 4/%0d", game_status, lives, SL + BONUS - 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (game_status !== 3'd0 || lives !== 4'd2 || world !== 3'd0 || level !== 3'd0 || level_start !== 1'b0) begin
            fails++; $display("FAIL mid_reset got st=%0d lv=%0d w=%0d l=%0d ls=%0d want 0/2/0/0/0",
                              game_status, lives, world, level, level_start);
        end
        tick();
        tests++;
        if (game_status !== 3'd0 || level_start !== 1'b0) begin
            fails++; $display("FAIL mid_stay got st=%0d ls=%0d want 0/0", game_status, level_start);
        end
    endtask

    task automatic test_back_to_back();
        int held;
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        player_status = 2'd1;
        tick();
        player_status = 2'd0;
        held = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (game_status == 3'd2) held++;
            else break;
        end
        tests++;
        if (held != HOLD || game_status !== 3'd1) begin
            fails++; $display("FAIL b2b_hold got n=%0d st=%0d want %0d/1", held, game_status, HOLD);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        start_btn = 1'b0;
        player_status = 2'd0;
        test_reset();
        test_start_hold();
        test_level_inc();
        test_world_inc_and_win();
        test_life_lost();
        test_reset_mid_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
